// File: rtl/csum_pkg.sv
// ---------------------------------------------------------------------------
// csum_pkg
// Shared constants for the 16-bit ones'-complement checksum blocks.
//   WIDTH          : data / checksum width (only 16 is supported)
//   IDLE/ACCUM/DONE: FSM state encoding used by ones_comp_csum16
//   CSUM_ALL_ONES  : all-ones word (ones'-complement negative zero)
// ---------------------------------------------------------------------------
package csum_pkg;

  localparam int WIDTH = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [WIDTH-1:0] CSUM_ALL_ONES = 16'hFFFF;

endpackage

// File: rtl/ones_add16.sv
// ---------------------------------------------------------------------------
// ones_add16
// Combinational 16-bit ones'-complement (end-around-carry) adder.
// Ports:
//   a [15:0] : first operand
//   b [15:0] : second operand
//   y [15:0] : (a + b) with the carry out folded back into bit 0
// The fold cannot carry again: the largest 17-bit sum is 0x1FFFE, which
// folds to 0xFFFF.
// ---------------------------------------------------------------------------
module ones_add16
  import csum_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] sum17;

  assign sum17 = {1'b0, a} + {1'b0, b};
  assign y     = sum17[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sum17[WIDTH]};

endmodule

// File: rtl/ones_comp_csum16.sv
// ---------------------------------------------------------------------------
// ones_comp_csum16
// Streaming 16-bit ones'-complement checksum generator. Words of a frame
// arrive over a valid/ready input and are accumulated with end-around carry;
// after the word marked s_last the complement of the sum is presented on a
// valid/ready result port together with the frame's word count.
//
// Parameters:
//   WIDTH : data / checksum width (only 16 supported)
//   CNT_W : word counter width; the counter saturates at 2^CNT_W-1
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   s_valid  : input word valid
//   s_ready  : block can accept a word (low only while a result is pending)
//   s_data   : input word
//   s_last   : final word of the frame, qualified by s_valid
//   m_valid  : checksum result valid
//   m_ready  : consumer accepts the result
//   m_csum   : checksum, ~acc, held stable until accepted
//   m_count  : number of words in the frame, held stable until accepted
//   busy     : a frame is in progress or a result is pending
//   m_ok     : (only with CSUM_VERIFY_EN) acc == 16'hFFFF, i.e. a frame that
//              carries its own checksum verified correctly
//
// Build option: define CSUM_VERIFY_EN to add the m_ok output.
// ---------------------------------------------------------------------------
module ones_comp_csum16
  import csum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_csum,
  output logic [CNT_W-1:0] m_count,
  output logic             busy
`ifdef CSUM_VERIFY_EN
  ,
  output logic             m_ok
`endif
);

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] csum_q;
  logic [CNT_W-1:0] count_q;

  logic             word_xfer;
  logic             res_xfer;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] count_next;

  // Handshakes and status derive directly from the state register.
  assign s_ready   = (state != DONE);
  assign m_valid   = (state == DONE);
  assign busy      = (state != IDLE);
  assign word_xfer = s_valid && s_ready;
  assign res_xfer  = m_valid && m_ready;

  // A word accepted in IDLE starts a new frame, so it is added to zero
  // rather than to whatever acc holds.
  assign add_a = (state == IDLE) ? '0 : acc;

  ones_add16 u_add (
    .a (add_a),
    .b (s_data),
    .y (acc_next)
  );

  always_comb begin
    count_next = count;
    if (state == IDLE) begin
      count_next = CNT_W'(1);
    end else if (!(&count)) begin
      count_next = count + CNT_W'(1);
    end
  end

  // Result registers are loaded from the next-state values on the last word,
  // so m_valid and the result appear together one cycle after that word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      csum_q  <= CSUM_ALL_ONES;
      count_q <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (word_xfer) begin
            acc   <= acc_next;
            count <= count_next;
            if (s_last) begin
              state   <= DONE;
              csum_q  <= ~acc_next;
              count_q <= count_next;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (res_xfer) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            csum_q  <= CSUM_ALL_ONES;
            count_q <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign m_csum  = csum_q;
  assign m_count = count_q;

`ifdef CSUM_VERIFY_EN
  logic ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q <= 1'b0;
    end else if ((state != DONE) && word_xfer && s_last) begin
      ok_q <= (acc_next == CSUM_ALL_ONES);
    end else if (res_xfer) begin
      ok_q <= 1'b0;
    end
  end

  assign m_ok = ok_q;
`endif

endmodule
